toggle_period_meter: RTL and testbench
======================================

Name: toggle_period_meter

Overview:
- Receive-side counterpart to the team's toggling slow-clock generators.
- Takes an asynchronous square wave (a divided clock, an external oscillator, or a board test pin) into the clk_in (100 MHz) domain.
- Measures its high time, low time and full period in clk_in cycles, and flags a stalled input.
- Used to verify divider settings on hardware and to recover dice/LED tick rates for display.

Parameters:
- CW, 16, width of the high/low cycle counters.
- SYNC_STAGES, 2, number of synchroniser flops on sig_in (minimum 2).
- TIMEOUT, 65535, cycles without an edge before the input is declared stalled (TIMEOUT ≤ 2^CW−1).

Ports:
- clk_in  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- sig_in  in  1  asynchronous square wave under measurement.
- high_cycles  out  CW  last measured high time, in clk_in cycles.
- low_cycles  out  CW  last measured low time, in clk_in cycles.
- period_cycles  out  CW+1  high_cycles+low_cycles, from the last complete period.
- meas_valid  out  1  one-cycle strobe: new period_cycles available.
- stalled  out  1  level: no edge seen for TIMEOUT cycles.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk_in. All outputs are 0 while reset is high, all internal state is cleared, and the FSM enters IDLE.
- Synchroniser:
  - sig_in passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - rise and fall are single-cycle pulses.
  - Latency from a sig_in transition to its pulse is SYNC_STAGES+1 cycles.
- Interval counter:
  - Counts clk_in cycles between consecutive edge pulses.
  - Reported value is exactly the pulse-to-pulse distance: edges 501 cycles apart report 501.
  - Saturates at TIMEOUT and never wraps.
- FSM states:
  - IDLE: wait for the first edge. The partial interval before it is discarded. Any edge -> ARM, counter restarts.
  - ARM: one edge seen.
    - Next edge captures the interval into high_cycles (on fall) or low_cycles (on rise) -> HALF.
  - HALF: one half-period known.
    - Next edge captures the other half -> RUN.
    - That edge is also treated as a RUN update, i.e. meas_valid fires if it is a rise.
  - RUN:
    - Every fall updates high_cycles.
    - Every rise updates low_cycles.
    - On every rise, period_cycles <= high_cycles + new low interval, and meas_valid is high for exactly one cycle, in the same cycle the registers update (one cycle after the rise pulse).
- Timeout (any state except IDLE):
  - When the counter reaches TIMEOUT with no edge: stalled <= 1, FSM -> IDLE.
  - high_cycles, low_cycles and period_cycles hold their last values; meas_valid does not fire.
  - In IDLE with stalled=1, the next edge clears stalled in the same cycle and starts ARM.
- Simultaneous timeout and edge in the same cycle: the edge wins (capture, no stall).
- Glitches shorter than one clk_in cycle may be lost in the synchroniser; this is not an error.
- An interval of 1 cycle (sig_in toggling every clk_in) is captured correctly as 1.
- period_cycles is CW+1 bits, so the addition cannot overflow.
- Reset mid-measurement:
  - Outputs clear immediately.
  - After release, at least two full half-periods plus a rise are needed before the first meas_valid.

Decomposition:
- Shared package (pig_pkg): FSM state encoding (IDLE, ARM, HALF, RUN) and the CW/TIMEOUT defaults. Typedef for the cycle count.
- One natural sub-module: sync_edge_detect (SYNC_STAGES-flop synchroniser plus rise/fall pulse outputs). The debounce path reuses it.
- Counter, FSM and capture registers stay in toggle_period_meter.

Test Plan:
1. Reset behaviour: hold reset, toggle sig_in -> all outputs 0. Release, then toggle sig_in every 501 cycles. -> First meas_valid on the 2nd rise after the first edge (or the 3rd edge overall, as the FSM dictates), with high_cycles=501, low_cycles=501, period_cycles=1002. meas_valid is exactly one cycle wide.
2. Asymmetric wave: high 300 / low 700 cycles. -> high_cycles=300, low_cycles=700, period_cycles=1000 on every rise after lock. No meas_valid on falls.
3. Stall: TIMEOUT=1000, a running 501/501 wave, then sig_in frozen high. -> stalled=1 exactly 1000 cycles after the last edge pulse; the last values are held. Resume toggling -> stalled drops on the first edge and meas_valid returns after re-lock.
4. Fastest input: sig_in toggling every clk_in cycle. -> high_cycles=1, low_cycles=1, period_cycles=2; meas_valid every 2 cycles once in RUN.
5. Edge race: an edge pulse arrives in the same cycle the counter hits TIMEOUT. -> The interval TIMEOUT is captured, stalled stays 0.
6. Reset mid-RUN: assert reset asynchronously between clock edges. -> Outputs go to 0 immediately. After release, the lock sequence repeats with no stale meas_valid.

Source files
------------

// File: rtl/toggle_period_meter_pkg.sv
// Shared types and defaults for the toggle period meter.
//   - meter_state_e : lock-in sequence of the measurement FSM
//   - cycle_t       : high/low time in clk_in cycles at the default width
//   - period_t      : full period, one bit wider so high+low cannot overflow
package toggle_period_meter_pkg;

    localparam int unsigned CW_DEFAULT          = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned TIMEOUT_DEFAULT     = 65535;

    typedef logic [CW_DEFAULT-1:0] cycle_t;
    typedef logic [CW_DEFAULT:0]   period_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no edge seen yet (or input stalled)
        ST_ARM  = 2'd1,   // one edge seen, first interval running
        ST_HALF = 2'd2,   // one half-period known
        ST_RUN  = 2'd3    // both halves known, periods reported on rises
    } meter_state_e;

    // Where the FSM goes after capturing an interval while locked or locking.
    function automatic meter_state_e next_lock_state(input meter_state_e s);
        meter_state_e n;
        n = ST_RUN;
        if (s == ST_ARM) begin
            n = ST_HALF;
        end
        return n;
    endfunction

endpackage

// File: rtl/toggle_period_meter_sync_edge_detect.sv
// Synchroniser and edge detector for an asynchronous level.
//   clk_in  : sampling clock
//   reset   : asynchronous, active-high
//   sig_in  : asynchronous input level
//   rise    : one-cycle pulse per synchronised 0->1 transition
//   fall    : one-cycle pulse per synchronised 1->0 transition
// A transition on sig_in shows up on rise/fall STAGES+1 cycles later.
// STAGES must be at least 2.
module toggle_period_meter_sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // Metastability chain, one history flop, then registered edge pulses.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_in};
            last_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~last_q;
            fall   <= ~sync_q[STAGES-1] & last_q;
        end
    end

endmodule

// File: rtl/toggle_period_meter.sv
// Measures high time, low time and period of an asynchronous square wave
// in clk_in cycles, and flags an input that stopped toggling.
//   clk_in        : system clock
//   reset         : asynchronous, active-high
//   sig_in        : asynchronous square wave under measurement
//   high_cycles   : last measured high time
//   low_cycles    : last measured low time
//   period_cycles : high_cycles + low interval, updated on every rise once locked
//   meas_valid    : one-cycle strobe, period_cycles just updated
//   stalled       : no edge for TIMEOUT cycles; cleared by the next edge
// TIMEOUT must lie in 1 .. 2**CW-1.
module toggle_period_meter
    import toggle_period_meter_pkg::*;
#(
    parameter int unsigned CW          = CW_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          sig_in,
    output logic [CW-1:0] high_cycles,
    output logic [CW-1:0] low_cycles,
    output logic [CW:0]   period_cycles,
    output logic          meas_valid,
    output logic          stalled
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic          rise;
    logic          fall;
    logic          edge_seen;
    logic          at_limit;
    logic [CW-1:0] interval;
    meter_state_e  state;

    toggle_period_meter_sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign edge_seen = rise | fall;
    assign at_limit  = (interval == LIMIT);

    // Interval counter, lock FSM and capture registers.
    // The counter restarts at 1 on an edge so that, in the cycle of the next
    // edge pulse, it holds exactly the pulse-to-pulse distance.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            interval      <= '0;
            high_cycles   <= '0;
            low_cycles    <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            stalled       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (edge_seen) begin
                interval <= CW'(1);
            end else if (!at_limit) begin
                interval <= interval + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    // Partial interval before the first edge is meaningless.
                    if (edge_seen) begin
                        state   <= ST_ARM;
                        stalled <= 1'b0;
                    end
                end

                ST_ARM, ST_HALF, ST_RUN: begin
                    // An edge in the same cycle as the limit wins over the stall.
                    if (edge_seen) begin
                        if (fall) begin
                            high_cycles <= interval;
                        end else begin
                            low_cycles <= interval;
                            // From HALF onwards a rise always follows a captured high.
                            if (state != ST_ARM) begin
                                period_cycles <= (CW+1)'(high_cycles) + (CW+1)'(interval);
                                meas_valid    <= 1'b1;
                            end
                        end
                        state <= next_lock_state(state);
                    end else if (at_limit) begin
                        stalled <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Self-checking bench for toggle_period_meter (CW=16, SYNC_STAGES=2, TIMEOUT=1000).
// Every cycle the outputs are compared against a timestamp-based reference:
// each sig_in toggle becomes an event that is visible four clocks after the
// drive edge, and intervals are simply differences of event times.
module tb_toggle_period_meter;

    localparam int unsigned CW  = 16;
    localparam int unsigned SS  = 2;
    localparam int unsigned TO  = 1000;
    localparam int unsigned LAT = SS + 2;   // drive edge -> registered output edge

    typedef struct {
        int unsigned vis;
        bit          rising;
    } ev_t;

    typedef struct {
        int unsigned   hi;
        int unsigned   lo;
        int unsigned   n;
        logic [CW-1:0] exp_high;
        logic [CW-1:0] exp_low;
        logic [CW:0]   exp_period;
    } row_t;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          sig_in;
    logic [CW-1:0] high_cycles;
    logic [CW-1:0] low_cycles;
    logic [CW:0]   period_cycles;
    logic          meas_valid;
    logic          stalled;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    // Reference model state.
    ev_t           evq[$];
    int unsigned   m_phase;     // number of edges since lock started, capped at 3
    int unsigned   m_last;
    logic [CW-1:0] m_high;
    logic [CW-1:0] m_low;
    logic [CW:0]   m_period;
    logic          m_valid;
    logic          m_stalled;

    row_t rows[5];

    toggle_period_meter #(
        .CW          (CW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .sig_in        (sig_in),
        .high_cycles   (high_cycles),
        .low_cycles    (low_cycles),
        .period_cycles (period_cycles),
        .meas_valid    (meas_valid),
        .stalled       (stalled)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Advance the reference by one cycle and compare all outputs.
    task automatic cycle_check();
        ev_t         ev;
        int unsigned gap;
        if (reset) begin
            evq.delete();
            m_phase   = 0;
            m_last    = 0;
            m_high    = '0;
            m_low     = '0;
            m_period  = '0;
            m_valid   = 1'b0;
            m_stalled = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (evq.size() != 0 && evq[0].vis <= cyc) begin
                ev  = evq.pop_front();
                gap = cyc - m_last;
                if (m_phase == 0) begin
                    m_phase   = 1;
                    m_stalled = 1'b0;
                end else begin
                    if (!ev.rising) begin
                        m_high = CW'(gap);
                    end else begin
                        m_low = CW'(gap);
                        if (m_phase >= 2) begin
                            m_period = (CW+1)'(m_high) + (CW+1)'(gap);
                            m_valid  = 1'b1;
                        end
                    end
                    if (m_phase < 3) m_phase++;
                end
                m_last = cyc;
            end else if (m_phase != 0 && (cyc - m_last) >= TO) begin
                m_stalled = 1'b1;
                m_phase   = 0;
            end
        end
        checks++;
        if (high_cycles !== m_high || low_cycles !== m_low || period_cycles !== m_period ||
            meas_valid !== m_valid || stalled !== m_stalled) begin
            failures++;
            $display("FAIL cycle_%0d outputs: got high=%0d low=%0d period=%0d valid=%0b stalled=%0b, expected high=%0d low=%0d period=%0d valid=%0b stalled=%0b",
                     cyc, high_cycles, low_cycles, period_cycles, meas_valid, stalled,
                     m_high, m_low, m_period, m_valid, m_stalled);
        end
    endtask

    // Each step ends 1 time unit after a rising clock edge.
    task automatic step(input int unsigned n);
        repeat (n) begin
            @(negedge clk_in);
            cycle_check();
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic drive(input logic v);
        if (v != sig_in && !reset) evq.push_back('{vis: cyc + LAT, rising: v});
        sig_in = v;
    endtask

    task automatic wave(input int unsigned hi, input int unsigned lo, input int unsigned n);
        for (int p = 0; p < int'(n); p++) begin
            drive(1'b1);
            step(hi);
            drive(1'b0);
            step(lo);
        end
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;

        rows[0] = '{hi: 501,  lo: 501,  n: 3, exp_high: 16'd501,  exp_low: 16'd501,  exp_period: 17'd1002};
        rows[1] = '{hi: 300,  lo: 700,  n: 3, exp_high: 16'd300,  exp_low: 16'd700,  exp_period: 17'd1000};
        rows[2] = '{hi: 1,    lo: 1,    n: 8, exp_high: 16'd1,    exp_low: 16'd1,    exp_period: 17'd2};
        rows[3] = '{hi: 1000, lo: 1000, n: 3, exp_high: 16'd1000, exp_low: 16'd1000, exp_period: 17'd2000};
        rows[4] = '{hi: 37,   lo: 5,    n: 4, exp_high: 16'd37,   exp_low: 16'd5,    exp_period: 17'd42};

        // Toggling under reset must leave every output at zero.
        step(3);
        drive(1'b1); step(2); drive(1'b0); step(2); drive(1'b1); step(1);
        check("reset_hold", {10'd0, high_cycles | low_cycles, period_cycles, meas_valid, stalled}, 32'd0);
        sig_in = 1'b0;
        step(3);
        reset = 1'b0;
        step(10);

        // Table of steady waves; values checked just after the last fall lands.
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < int'(rows[r].n); p++) begin
                drive(1'b1);
                step(rows[r].hi);
                drive(1'b0);
                if (p == int'(rows[r].n) - 1) begin
                    step(6);
                    check($sformatf("row%0d_high", r), 32'(high_cycles), 32'(rows[r].exp_high));
                    check($sformatf("row%0d_low", r), 32'(low_cycles), 32'(rows[r].exp_low));
                    check($sformatf("row%0d_period", r), 32'(period_cycles), 32'(rows[r].exp_period));
                    check($sformatf("row%0d_stalled", r), 32'(stalled), 32'd0);
                    if (rows[r].lo > 6) step(rows[r].lo - 6);
                end else begin
                    step(rows[r].lo);
                end
            end
        end

        // Stall: freeze high after a 501/501 wave, then resume.
        drive(1'b1); step(501); drive(1'b0); step(501); drive(1'b1);
        step(TO + LAT - 1);
        check("stall_not_early", 32'(stalled), 32'd0);
        step(1);
        check("stall_asserted", 32'(stalled), 32'd1);
        check("stall_hold_high", 32'(high_cycles), 32'd501);
        check("stall_hold_low", 32'(low_cycles), 32'd501);
        check("stall_hold_period", 32'(period_cycles), 32'd1002);
        step(50);
        check("stall_no_valid", 32'(meas_valid), 32'd0);
        drive(1'b0);
        step(LAT);
        check("stall_cleared", 32'(stalled), 32'd0);
        step(497);
        wave(501, 501, 3);

        // Random waves, occasionally longer than the timeout or very short.
        for (int i = 0; i < 25; i++) begin
            int unsigned h;
            int unsigned l;
            h = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 4) : $urandom_range(1, 1100);
            l = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 4) : $urandom_range(1, 1100);
            wave(h, l, 1);
        end

        // Reset between clock edges in the middle of a running measurement.
        wave(300, 700, 2);
        drive(1'b1);
        step(300);
        drive(1'b0);
        step(200);
        #2 reset = 1'b1;
        #1;
        check("async_reset_immediate",
              {10'd0, high_cycles | low_cycles, period_cycles, meas_valid, stalled}, 32'd0);
        sig_in = 1'b0;
        step(5);
        reset = 1'b0;
        step(20);
        wave(400, 400, 3);
        drive(1'b1);
        step(10);
        check("relock_period", 32'(period_cycles), 32'd800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
